// File: rtl/stf_detector.sv
// stf_detector: receive-side 802.11 L-STF detector.
// Runs a lag-16 delayed autocorrelation over a 16-sample window and
// normalises it against the windowed power. It flags a short preamble once
// MIN_PLATEAU consecutive samples qualify.
//
// Ports:
//   clock            sole clock
//   reset            synchronous, active-high; clears all state
//   restart          synchronous re-arm; same effect as reset
//   sample_in_strobe sample_in is valid this cycle
//   sample_in        signed I [31:16], signed Q [15:0]
//   detected         level, high from detection until reset/restart
//   detect_pulse     one-cycle pulse on detection
//   phase_corr_i/q   latched correlation bits [36:21] at detection
//
// Optional feature macro: STF_DET_CFO_EST_EN
//   defined   -> phase_corr_i/q latch the correlation sums that caused detection
//   undefined -> phase_corr_i/q are constant 0 and no latch registers exist
module stf_detector #(
  parameter int unsigned THRESH      = 12,
  parameter logic [36:0] MIN_POWER   = 37'd4096,
  parameter int unsigned MIN_PLATEAU = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        restart,
  input  logic        sample_in_strobe,
  input  logic [31:0] sample_in,
  output logic        detected,
  output logic        detect_pulse,
  output logic [15:0] phase_corr_i,
  output logic [15:0] phase_corr_q
);

  typedef enum logic {ST_SEARCH, ST_DETECTED} state_t;

  logic w_clr;
  assign w_clr = reset | restart;

  function automatic logic [36:0] abs37(input logic signed [36:0] v);
    abs37 = v[36] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // max + min/2 approximation of the complex magnitude
  function automatic logic [37:0] mag_est(input logic signed [36:0] re,
                                          input logic signed [36:0] im);
    logic [36:0] a, b, hi, lo;
    a = abs37(re);
    b = abs37(im);
    if (a >= b) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    mag_est = {1'b0, hi} + {2'b00, lo[36:1]};
  endfunction

  // 16*M >= THRESH*P and P > MIN_POWER, evaluated without division
  function automatic logic qualify(input logic signed [36:0] re,
                                   input logic signed [36:0] im,
                                   input logic signed [36:0] p);
    logic [42:0] lhs, rhs;
    lhs = {1'b0, mag_est(re, im), 4'b0000};
    rhs = 43'($unsigned(p)) * 43'(THRESH);
    qualify = (lhs >= rhs) && ($unsigned(p) > MIN_POWER);
  endfunction

  // ---- input capture ----
  logic signed [15:0] r_i_p0, r_q_p0;
  logic               vld_p0;

  always_ff @(posedge clock) begin
    if (w_clr) begin
      vld_p0 <= 1'b0;
      r_i_p0 <= '0;
      r_q_p0 <= '0;
    end else begin
      vld_p0 <= sample_in_strobe;
      if (sample_in_strobe) begin
        r_i_p0 <= sample_in[31:16];
        r_q_p0 <= sample_in[15:0];
      end
    end
  end

  // ---- S1: delay line, products, power term, warm-up ----
  logic signed [15:0] r_dly_i [16];
  logic signed [15:0] r_dly_q [16];
  logic signed [32:0] w_re, w_im, w_pw;
  logic signed [32:0] r_re_p1, r_im_p1, r_pw_p1;
  logic               vld_p1, r_warm_p1;
  logic [5:0]         r_warm_cnt;

  assign w_re = 33'(r_i_p0) * 33'(r_dly_i[15]) + 33'(r_q_p0) * 33'(r_dly_q[15]);
  assign w_im = 33'(r_q_p0) * 33'(r_dly_i[15]) - 33'(r_i_p0) * 33'(r_dly_q[15]);
  assign w_pw = 33'(r_i_p0) * 33'(r_i_p0) + 33'(r_q_p0) * 33'(r_q_p0);

  always_ff @(posedge clock) begin
    if (w_clr) begin
      for (int k = 0; k < 16; k++) begin
        r_dly_i[k] <= '0;
        r_dly_q[k] <= '0;
      end
      r_re_p1    <= '0;
      r_im_p1    <= '0;
      r_pw_p1    <= '0;
      vld_p1     <= 1'b0;
      r_warm_p1  <= 1'b0;
      r_warm_cnt <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        r_dly_i[0] <= r_i_p0;
        r_dly_q[0] <= r_q_p0;
        for (int k = 1; k < 16; k++) begin
          r_dly_i[k] <= r_dly_i[k-1];
          r_dly_q[k] <= r_dly_q[k-1];
        end
        r_re_p1   <= w_re;
        r_im_p1   <= w_im;
        r_pw_p1   <= w_pw;
        // the 32nd strobe (index 31) is the first with a full correlation window
        r_warm_p1 <= (r_warm_cnt >= 6'd31);
        if (r_warm_cnt != 6'd63) r_warm_cnt <= r_warm_cnt + 6'd1;
      end
    end
  end

  // ---- S2: moving sums over the last 16 strobes ----
  logic signed [32:0] r_hre [16];
  logic signed [32:0] r_him [16];
  logic signed [32:0] r_hpw [16];
  logic signed [36:0] r_cre_p2, r_cim_p2, r_p_p2;
  logic               vld_p2, r_warm_p2;

  always_ff @(posedge clock) begin
    if (w_clr) begin
      for (int k = 0; k < 16; k++) begin
        r_hre[k] <= '0;
        r_him[k] <= '0;
        r_hpw[k] <= '0;
      end
      r_cre_p2  <= '0;
      r_cim_p2  <= '0;
      r_p_p2    <= '0;
      vld_p2    <= 1'b0;
      r_warm_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        r_hre[0] <= r_re_p1;
        r_him[0] <= r_im_p1;
        r_hpw[0] <= r_pw_p1;
        for (int k = 1; k < 16; k++) begin
          r_hre[k] <= r_hre[k-1];
          r_him[k] <= r_him[k-1];
          r_hpw[k] <= r_hpw[k-1];
        end
        r_cre_p2  <= r_cre_p2 + 37'(r_re_p1) - 37'(r_hre[15]);
        r_cim_p2  <= r_cim_p2 + 37'(r_im_p1) - 37'(r_him[15]);
        r_p_p2    <= r_p_p2 + 37'(r_pw_p1) - 37'(r_hpw[15]);
        r_warm_p2 <= r_warm_p1;
      end
    end
  end

  // ---- S3: qualification compare ----
  logic vld_p3, r_qual_p3;
`ifdef STF_DET_CFO_EST_EN
  logic [15:0] r_cre_p3, r_cim_p3;
`endif

  always_ff @(posedge clock) begin
    if (w_clr) begin
      vld_p3    <= 1'b0;
      r_qual_p3 <= 1'b0;
`ifdef STF_DET_CFO_EST_EN
      r_cre_p3  <= '0;
      r_cim_p3  <= '0;
`endif
    end else begin
      vld_p3    <= vld_p2;
      r_qual_p3 <= vld_p2 && r_warm_p2 && qualify(r_cre_p2, r_cim_p2, r_p_p2);
`ifdef STF_DET_CFO_EST_EN
      r_cre_p3  <= r_cre_p2[36:21];
      r_cim_p3  <= r_cim_p2[36:21];
`endif
    end
  end

  // ---- S4: plateau counter and detection FSM ----
  state_t     r_state;
  logic [7:0] r_plat_cnt;
  logic       r_detected, r_pulse;
  logic       w_plat_done;

  assign w_plat_done = (r_plat_cnt == 8'(MIN_PLATEAU - 1));

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_state    <= ST_SEARCH;
      r_plat_cnt <= '0;
      r_detected <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (vld_p3 && r_state == ST_SEARCH) begin
        if (r_qual_p3) begin
          r_plat_cnt <= r_plat_cnt + 8'd1;
          if (w_plat_done) begin
            r_state    <= ST_DETECTED;
            r_detected <= 1'b1;
            r_pulse    <= 1'b1;
          end
        end else begin
          r_plat_cnt <= '0;
        end
      end
    end
  end

  assign detected     = r_detected;
  assign detect_pulse = r_pulse;

`ifdef STF_DET_CFO_EST_EN
  logic [15:0] r_pci, r_pcq;

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_pci <= '0;
      r_pcq <= '0;
    end else if (vld_p3 && r_state == ST_SEARCH && r_qual_p3 && w_plat_done) begin
      r_pci <= r_cre_p3;
      r_pcq <= r_cim_p3;
    end
  end

  assign phase_corr_i = r_pci;
  assign phase_corr_q = r_pcq;
`else
  assign phase_corr_i = 16'h0000;
  assign phase_corr_q = 16'h0000;
`endif

endmodule

// File: tb/tb_stf_detector.sv
// Self-checking bench for stf_detector. A window-sum model recomputes every
// strobe's correlation and power from the raw sample history and predicts
// the detection edge and latched phase; outputs are compared every cycle.
module tb_stf_detector;

  localparam int    THRESH      = 12;
  localparam longint MIN_POWER  = 4096;
  localparam int    MIN_PLATEAU = 48;

  logic        clock = 1'b0;
  logic        reset = 1'b1, restart = 1'b0, sample_in_strobe = 1'b0;
  logic [31:0] sample_in = '0;
  logic        detected, detect_pulse;
  logic [15:0] phase_corr_i, phase_corr_q;

  always #5 clock = ~clock;

  stf_detector dut (
    .clock           (clock),
    .reset           (reset),
    .restart         (restart),
    .sample_in_strobe(sample_in_strobe),
    .sample_in       (sample_in),
    .detected        (detected),
    .detect_pulse    (detect_pulse),
    .phase_corr_i    (phase_corr_i),
    .phase_corr_q    (phase_corr_q)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state
  longint      mi[$];
  longint      mq[$];
  int          plat;
  bit          mdet;
  int          det_idx;
  int          exp_pulse_edge;
  logic [15:0] exp_pi, exp_pq;
  int          edge_no = 0;

  // per-test bookkeeping
  int glob;
  int strobe_edge [0:1023];
  int dut_pulses;
  int dut_pulse_edge;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
    end
  endtask

  task automatic model_clear();
    mi.delete();
    mq.delete();
    plat           = 0;
    mdet           = 1'b0;
    det_idx        = -1;
    exp_pulse_edge = -1;
    exp_pi         = '0;
    exp_pq         = '0;
  endtask

  task automatic model_strobe(input logic signed [15:0] si, input logic signed [15:0] sq,
                              input int e);
    longint cre, cim, p, a, b, m, xi, xq, di, dq, t;
    int     n;
    bit     qual;
    mi.push_back(longint'(si));
    mq.push_back(longint'(sq));
    n   = mi.size() - 1;
    cre = 0;
    cim = 0;
    p   = 0;
    for (int j = n - 15; j <= n; j++) begin
      if (j >= 0) begin
        xi = mi[j];
        xq = mq[j];
        di = (j >= 16) ? mi[j-16] : 0;
        dq = (j >= 16) ? mq[j-16] : 0;
        cre += xi * di + xq * dq;
        cim += xq * di - xi * dq;
        p   += xi * xi + xq * xq;
      end
    end
    a = (cre < 0) ? -cre : cre;
    b = (cim < 0) ? -cim : cim;
    m = (a >= b) ? a + (b >> 1) : b + (a >> 1);
    qual = (n >= 31) && (16 * m >= THRESH * p) && (p > MIN_POWER);
    if (!mdet) begin
      plat = qual ? plat + 1 : 0;
      if (plat == MIN_PLATEAU) begin
        mdet           = 1'b1;
        det_idx        = n;
        exp_pulse_edge = e + 4;
        t              = cre >>> 21;
        exp_pi         = t[15:0];
        t              = cim >>> 21;
        exp_pq         = t[15:0];
      end
    end
  endtask

  task automatic check_outputs();
    bit          e_det, e_pulse;
    logic [15:0] e_pi, e_pq;
    e_det   = (exp_pulse_edge >= 0) && (edge_no >= exp_pulse_edge);
    e_pulse = (edge_no == exp_pulse_edge);
`ifdef STF_DET_CFO_EST_EN
    e_pi = e_det ? exp_pi : 16'h0000;
    e_pq = e_det ? exp_pq : 16'h0000;
`else
    e_pi = 16'h0000;
    e_pq = 16'h0000;
`endif
    chk("detect_pulse", 32'(detect_pulse), 32'(e_pulse));
    chk("detected", 32'(detected), 32'(e_det));
    chk("phase_corr_i", 32'(phase_corr_i), 32'(e_pi));
    chk("phase_corr_q", 32'(phase_corr_q), 32'(e_pq));
    if (detect_pulse === 1'b1) begin
      dut_pulses++;
      dut_pulse_edge = edge_no;
    end
  endtask

  task automatic step(input bit rst, input bit rs, input bit stb, input logic [31:0] s);
    reset            = rst;
    restart          = rs;
    sample_in_strobe = stb;
    sample_in        = s;
    if (stb) begin
      if (glob < 1024) strobe_edge[glob] = edge_no + 1;
      glob++;
    end
    if (rst || rs) model_clear();
    else if (stb) model_strobe(s[31:16], s[15:0], edge_no + 1);
    @(posedge clock);
    edge_no++;
    #1;
    check_outputs();
  endtask

  task automatic begin_test();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    glob           = 0;
    dut_pulses     = 0;
    dut_pulse_edge = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  function automatic logic [15:0] rnd(input real x);
    int v;
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    return v[15:0];
  endfunction

  // 802.11a L-STF period, scaled by 8192
  logic [31:0] stf_tab [16] = '{
    {16'sd377,   16'sd377},   {-16'sd1081, 16'sd16},
    {-16'sd106, -16'sd647},   {16'sd1171, -16'sd106},
    {16'sd754,   16'sd0},     {16'sd1171, -16'sd106},
    {-16'sd106, -16'sd647},   {-16'sd1081, 16'sd16},
    {16'sd377,   16'sd377},   {16'sd16,  -16'sd1081},
    {-16'sd647, -16'sd106},   {-16'sd106, 16'sd1171},
    {16'sd0,     16'sd754},   {-16'sd106, 16'sd1171},
    {-16'sd647, -16'sd106},   {16'sd16,  -16'sd1081}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pi_v, pq_v;
    glob = 0;
    dut_pulses = 0;
    dut_pulse_edge = -1;
    model_clear();

    // reset with random inputs, then a bare restart
    step(1'b1, 1'b0, 1'($urandom), $urandom);
    step(1'b1, 1'b0, 1'($urandom), $urandom);
    step(1'b0, 1'b1, 1'b0, $urandom);
    idle(4);
    chk("idle_no_pulse", 32'(dut_pulses), 32'd0);

    // constant input
    begin_test();
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, {16'h0400, 16'h0000});
    idle(6);
    chk("const_model_idx", 32'(det_idx), 32'd78);
    chk("const_pulses", 32'(dut_pulses), 32'd1);
    chk("const_pulse_edge", 32'(dut_pulse_edge), 32'(strobe_edge[78] + 4));
    chk("const_detected", 32'(detected), 32'd1);
`ifdef STF_DET_CFO_EST_EN
    chk("const_phase_i", 32'(phase_corr_i), 32'd8);
    chk("const_phase_q", 32'(phase_corr_q), 32'd0);
`endif

    // restart alongside strobe index 50
    begin_test();
    for (int i = 0; i < 160; i++) step(1'b0, (i == 50), 1'b1, {16'h0400, 16'h0000});
    idle(6);
    chk("restart_model_idx", 32'(det_idx), 32'd78);
    chk("restart_pulses", 32'(dut_pulses), 32'd1);
    chk("restart_pulse_edge", 32'(dut_pulse_edge), 32'(strobe_edge[129] + 4));

    // all-zero input
    begin_test();
    for (int i = 0; i < 500; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(6);
    chk("zero_pulses", 32'(dut_pulses), 32'd0);
    chk("zero_detected", 32'(detected), 32'd0);

    // rotating input, pi/32 per strobe
    begin_test();
    for (int i = 0; i < 100; i++)
      step(1'b0, 1'b0, 1'b1, {rnd(1024.0 * $cos(3.14159265358979 * i / 32.0)),
                              rnd(1024.0 * $sin(3.14159265358979 * i / 32.0))});
    idle(6);
    chk("rot_pulses", 32'(dut_pulses), 32'd1);
    chk("rot_pulse_edge", 32'(dut_pulse_edge), 32'(strobe_edge[78] + 4));
`ifdef STF_DET_CFO_EST_EN
    pi_v = phase_corr_i;
    pq_v = phase_corr_q;
    chk("rot_phase_i_small", 32'(($signed(pi_v) <= 2) && ($signed(pi_v) >= -2)), 32'd1);
    chk("rot_phase_q_pos", 32'($signed(pq_v) > 0), 32'd1);
`endif

    // zeros, 10 L-STF periods, zeros; one idle cycle between strobes
    begin_test();
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      idle(1);
    end
    for (int r = 0; r < 10; r++)
      for (int k = 0; k < 16; k++) begin
        step(1'b0, 1'b0, 1'b1, stf_tab[k]);
        idle(1);
      end
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      idle(1);
    end
    idle(6);
    chk("stf_pulses", 32'(dut_pulses), 32'd1);
    chk("stf_detected", 32'(detected), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
